// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths, FSM encoding and constants for the arithmetic datapath
// Purpose : common definitions for seq_divider22 and its div_step helper.
// Contents: W / DW / CW widths, divider FSM state type, divide-by-zero quotient.
package arith_pkg;

   localparam int W  = 11;               // divisor / remainder width
   localparam int DW = 2 * W;            // dividend / quotient width
   localparam int CW = $clog2(DW + 1);   // iteration counter width (holds 0..DW)

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   // Quotient reported when the divisor is zero: all ones.
   localparam logic [DW-1:0] DZ_QUOT = {DW{1'b1}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division step (shift, trial subtract, restore)
// Purpose : combinational single-bit iteration of the restoring divider.
// Ports   : i_rem     partial remainder in  (W+1)
//           i_dvd     dividend/quotient shift register in (DW)
//           i_divisor divisor (W)
//           o_rem     partial remainder out (W+1)
//           o_dvd     shift register out, new quotient bit in the LSB (DW)
module div_step
   import arith_pkg::*;
(
   input  logic [W:0]    i_rem,
   input  logic [DW-1:0] i_dvd,
   input  logic [W-1:0]  i_divisor,
   output logic [W:0]    o_rem,
   output logic [DW-1:0] o_dvd
);

   logic [W+1:0] w_shift;
   logic [W+1:0] w_diff;
   logic         w_fits;

   // The shifted remainder is always below 2^(W+1), so one extra bit is
   // enough for the difference's sign to tell whether the divisor fits.
   assign w_shift = {i_rem, i_dvd[DW-1]};
   assign w_diff  = w_shift - {2'b00, i_divisor};
   assign w_fits  = ~w_diff[W+1];

   assign o_rem = w_fits ? w_diff[W:0] : w_shift[W:0];
   assign o_dvd = {i_dvd[DW-2:0], w_fits};

endmodule

// File: rtl/seq_divider22.sv
// rtl/seq_divider22.sv - iterative radix-2 restoring divider, 2W-bit dividend by W-bit divisor
// Purpose : one division in flight, valid/ready on both sides, 2W iterations per result.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready, dividend (2W), divisor (W)    - operand side
//           out_valid/out_ready, quotient (2W), remainder (W),
//           div_zero                                         - result side
module seq_divider22
   import arith_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [W-1:0]  divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [W-1:0]  remainder,
   output logic          div_zero
);

   div_state_t    r_state;
   div_state_t    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [W:0]    r_rem;
   logic [DW-1:0] r_dvd;
   logic [W-1:0]  r_dsr;
   logic [DW-1:0] r_quot;
   logic [W-1:0]  r_remo;
   logic          r_dz;

   logic          w_accept;
   logic          w_last;
   logic [W:0]    w_rem_nxt;
   logic [DW-1:0] w_dvd_nxt;

   div_step u_step (
      .i_rem     (r_rem),
      .i_dvd     (r_dvd),
      .i_divisor (r_dsr),
      .o_rem     (w_rem_nxt),
      .o_dvd     (w_dvd_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == CW'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Working registers plus the visible result registers; the latter only
   // move on entry to DONE so the last result stays readable through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_rem  <= '0;
         r_dvd  <= '0;
         r_dsr  <= '0;
         r_quot <= '0;
         r_remo <= '0;
         r_dz   <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= CW'(DW);
         r_rem <= '0;
         r_dvd <= dividend;
         r_dsr <= divisor;
         if (divisor == '0) begin
            r_quot <= DZ_QUOT;
            r_remo <= '0;
            r_dz   <= 1'b1;
         end
      end else if (r_state == ST_CALC) begin
         r_cnt <= r_cnt - CW'(1);
         r_rem <= w_rem_nxt;
         r_dvd <= w_dvd_nxt;
         if (w_last) begin
            r_quot <= w_dvd_nxt;
            r_remo <= w_rem_nxt[W-1:0];
            r_dz   <= 1'b0;
         end
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign quotient  = r_quot;
   assign remainder = r_remo;
   assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider22.sv
// tb/tb_seq_divider22.sv - self-checking bench for seq_divider22
module tb_seq_divider22;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] dividend;
   logic [10:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] quotient;
   logic [10:0] remainder;
   logic        div_zero;

   int n_cmp;
   int n_err;

   seq_divider22 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] a;
      logic [10:0] b;
      logic [21:0] q;
      logic [10:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Waits for in_ready, presents one operand pair, then waits for out_valid.
   // Latency counts the accept edge as 1. Result is popped unless hold=1.
   task automatic run_op(input logic [21:0] a, input logic [10:0] b, input bit hold,
                         output logic [21:0] q, output logic [10:0] r,
                         output logic dz, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 22'($urandom);
      divisor  = 11'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      q  = quotient;
      r  = remainder;
      dz = div_zero;
      if (!hold) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   initial begin
      logic [21:0] q;
      logic [10:0] r;
      logic        dz;
      int          lat;
      logic [21:0] ra;
      logic [10:0] rb;
      logic [21:0] eq;
      logic [10:0] er;

      n_cmp = 0;
      n_err = 0;

      vecs[0] = '{22'd133245,  11'd135,  22'd987,     11'd0,   1'b0, 23};
      vecs[1] = '{22'd525056,  11'd681,  22'd771,     11'd5,   1'b0, 23};
      vecs[2] = '{22'd21,      11'd3,    22'd7,       11'd0,   1'b0, 23};
      vecs[3] = '{22'd100,     11'd2047, 22'd0,       11'd100, 1'b0, 23};
      vecs[4] = '{22'd4194303, 11'd1,    22'd4194303, 11'd0,   1'b0, 23};
      vecs[5] = '{22'd1234,    11'd0,    22'd4194303, 11'd0,   1'b1, 1};
      vecs[6] = '{22'd0,       11'd5,    22'd0,       11'd0,   1'b0, 23};
      vecs[7] = '{22'd4194303, 11'd2047, 22'd2049,    11'd0,   1'b0, 23};
      vecs[8] = '{22'd1000,    11'd7,    22'd142,     11'd6,   1'b0, 23};
      vecs[9] = '{22'd2046,    11'd2047, 22'd0,       11'd2046, 1'b0, 23};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready",  in_ready,  1);
      chk("reset out_valid", out_valid, 0);
      chk("reset quotient",  quotient,  0);
      chk("reset remainder", remainder, 0);
      chk("reset div_zero",  div_zero,  0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, q, r, dz, lat);
         chk($sformatf("vec%0d quotient", i),  q,   vecs[i].q);
         chk($sformatf("vec%0d remainder", i), r,   vecs[i].r);
         chk($sformatf("vec%0d div_zero", i),  dz,  vecs[i].dz);
         chk($sformatf("vec%0d latency", i),   lat, vecs[i].lat);
      end

      // Backpressure after a divide-by-zero: result must hold, no new accept.
      run_op(22'd1234, 11'd0, 1'b1, q, r, dz, lat);
      in_valid = 1'b1;
      dividend = 22'd21;
      divisor  = 11'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp out_valid", out_valid, 1);
         chk("bp in_ready",  in_ready,  0);
         chk("bp quotient",  quotient,  22'd4194303);
         chk("bp div_zero",  div_zero,  1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp idle in_ready",  in_ready,  1);
      chk("bp idle out_valid", out_valid, 0);
      chk("bp idle quotient held", quotient, 22'd4194303);
      run_op(22'd21, 11'd3, 1'b0, q, r, dz, lat);
      chk("after dz quotient", q,  7);
      chk("after dz div_zero", dz, 0);

      // New operands pulsed mid-CALC must be ignored.
      dividend = 22'd133245;
      divisor  = 11'd135;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("calc in_ready", in_ready, 0);
      dividend = 22'd21;
      divisor  = 11'd0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("ignore quotient",  quotient,  987);
      chk("ignore remainder", remainder, 0);
      chk("ignore div_zero",  div_zero,  0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in CALC cycle 7 aborts at once.
      dividend = 22'd525056;
      divisor  = 11'd681;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort out_valid", out_valid, 0);
      chk("abort in_ready",  in_ready,  1);
      chk("abort quotient",  quotient,  0);
      chk("abort remainder", remainder, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(22'd133245, 11'd135, 1'b0, q, r, dz, lat);
      chk("post-abort quotient",  q,   987);
      chk("post-abort remainder", r,   0);
      chk("post-abort latency",   lat, 23);

      // Random pairs back to back against a reference model.
      for (int k = 0; k < 300; k++) begin
         ra = 22'($urandom_range(0, 4194303));
         rb = (k % 25 == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
         if (rb == 0) begin
            eq = 22'h3FFFFF;
            er = '0;
         end else begin
            eq = ra / 22'(rb);
            er = 11'(ra % 22'(rb));
         end
         run_op(ra, rb, 1'b0, q, r, dz, lat);
         chk($sformatf("rand %0d/%0d quotient", ra, rb),  q, eq);
         chk($sformatf("rand %0d/%0d remainder", ra, rb), r, er);
         chk($sformatf("rand %0d/%0d div_zero", ra, rb),  dz, (rb == 0) ? 1 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
